// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - E-stage mult/div request, divider handshake and HI/LO result bundle
interface muldiv_seq_if;
    logic        multE;
    logic        multuE;
    logic        divE;
    logic        divuE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        pipe_stall;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        stall_req;
    logic        res_valid;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        busy;

    modport master (
        output multE, multuE, divE, divuE, srcaE, srcbE, flushE, pipe_stall,
        output div_ready, div_result,
        input  div_start, div_signed, div_annul, div_opa, div_opb,
        input  stall_req, res_valid, res_hi, res_lo, busy
    );

    modport slave (
        input  multE, multuE, divE, divuE, srcaE, srcbE, flushE, pipe_stall,
        input  div_ready, div_result,
        output div_start, div_signed, div_annul, div_opa, div_opb,
        output stall_req, res_valid, res_hi, res_lo, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the execute stage
module muldiv_seq #(
    parameter int MUL_CYCLES = 2
) (
    input logic         clka,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int               CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        req;
    logic        req_div;
    logic        req_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    // Priority divE > divuE > multE > multuE decides both kind and signedness.
    always_comb begin
        req        = bus.divE | bus.divuE | bus.multE | bus.multuE;
        req_div    = bus.divE | bus.divuE;
        req_signed = bus.divE | (~bus.divuE & bus.multE);
        ext_a      = signed_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
        ext_b      = signed_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
        product    = ext_a * ext_b;
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (req && !bus.flushE) begin
                    opa_d    = bus.srcaE;
                    opb_d    = bus.srcbE;
                    signed_d = req_signed;
                    if (req_div) begin
                        state_d = DIV_RUN;
                    end else begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DIV_RUN: begin
                if (bus.flushE) begin
                    state_d = IDLE;
                end else if (bus.div_ready) begin
                    hi_d    = bus.div_result[63:32];
                    lo_d    = bus.div_result[31:0];
                    state_d = DONE;
                end
            end
            MUL_RUN: begin
                if (bus.flushE) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // A held pipeline keeps the same instruction in E; it is never re-run.
                if (bus.flushE || !bus.pipe_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Only the accept path and the divider abort look at live E-stage inputs.
    assign bus.stall_req  = ((state_q == IDLE) & req & ~bus.flushE)
                          | ((state_q == DIV_RUN) & ~bus.flushE)
                          | (state_q == MUL_RUN);
    assign bus.div_annul  = (state_q == DIV_RUN) & bus.flushE;
    assign bus.div_start  = (state_q == DIV_RUN);
    assign bus.div_signed = signed_q;
    assign bus.div_opa    = opa_q;
    assign bus.div_opb    = opb_q;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_hi     = hi_q;
    assign bus.res_lo     = lo_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - bench for muldiv_seq: vector table, corner sequences, random ops
module tb_muldiv_seq;
    localparam int MUL_CYCLES = 2;

    typedef enum int {OP_DIV, OP_DIVU, OP_MULT, OP_MULTU} op_t;

    typedef struct {
        logic [3:0]  lines;
        logic [31:0] a;
        logic [31:0] b;
        int          dlat;
        int          pst;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clka = 1'b0;
    logic rst;
    muldiv_seq_if m ();

    muldiv_seq #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (m.slave)
    );

    always #5 clka = ~clka;

    int          n_vec = 0;
    int          n_miss = 0;
    int          div_lat = 33;
    int          dcnt = 0;
    int          annul_cnt = 0;
    logic        stray_ready = 1'b0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    function automatic logic [63:0] ref_model(input op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic op_t prio(input logic [3:0] lines);
        if (lines[3]) return OP_DIV;
        if (lines[2]) return OP_DIVU;
        if (lines[1]) return OP_MULT;
        return OP_MULTU;
    endfunction

    // Divider model: ready pulses div_lat cycles after div_start rises; an annul restarts it.
    always @(posedge clka) begin
        logic rdy;
        #2;
        rdy = 1'b0;
        if (rst || !m.div_start) begin
            dcnt = 0;
        end else begin
            dcnt++;
            rdy = (dcnt == div_lat + 1);
        end
        if (rdy)
            m.div_result = ref_model(m.div_signed ? OP_DIV : OP_DIVU, m.div_opa, m.div_opb);
        else
            m.div_result = 64'hDEAD_BEEF_0BAD_F00D;
        if (m.div_annul) begin
            annul_cnt++;
            dcnt = 0;
        end
        m.div_ready = rdy | stray_ready;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        {m.divE, m.divuE, m.multE, m.multuE} = 4'b0000;
        m.srcaE      = 32'd0;
        m.srcbE      = 32'd0;
        m.flushE     = 1'b0;
        m.pipe_stall = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " stall_req"}, m.stall_req, 1'b0);
        chk1({tag, " busy"}, m.busy, 1'b0);
        chk1({tag, " res_valid"}, m.res_valid, 1'b0);
        chk1({tag, " div_start"}, m.div_start, 1'b0);
        chk1({tag, " div_signed"}, m.div_signed, 1'b0);
        chk1({tag, " div_annul"}, m.div_annul, 1'b0);
        chk32({tag, " div_opa"}, m.div_opa, 32'd0);
        chk32({tag, " div_opb"}, m.div_opb, 32'd0);
        chk32({tag, " res_hi"}, m.res_hi, 32'd0);
        chk32({tag, " res_lo"}, m.res_lo, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] lines, input logic [31:0] a,
                         input logic [31:0] b, input int dlat, input int pst,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic is_div;
        logic exp_sgn;
        int   done_c;
        is_div  = (prio(lines) == OP_DIV) || (prio(lines) == OP_DIVU);
        exp_sgn = (prio(lines) == OP_DIV) || (prio(lines) == OP_MULT);
        done_c  = is_div ? dlat + 2 : MUL_CYCLES + 1;
        div_lat = dlat;
        next_cycle();
        {m.divE, m.divuE, m.multE, m.multuE} = lines;
        m.srcaE = a;
        m.srcbE = b;
        settle();
        chk1($sformatf("%s accept stall_req", tag), m.stall_req, 1'b1);
        chk1($sformatf("%s accept busy", tag), m.busy, 1'b0);
        for (int c = 1; c <= done_c + pst; c++) begin
            next_cycle();
            m.srcaE      = $urandom;
            m.srcbE      = $urandom;
            m.pipe_stall = (c >= done_c) && (c < done_c + pst);
            settle();
            if (c < done_c) begin
                chk1($sformatf("%s c%0d stall_req", tag, c), m.stall_req, 1'b1);
                chk1($sformatf("%s c%0d res_valid", tag, c), m.res_valid, 1'b0);
                chk1($sformatf("%s c%0d div_start", tag, c), m.div_start, is_div);
                if (is_div && c == 1) begin
                    chk1($sformatf("%s div_signed", tag), m.div_signed, exp_sgn);
                    chk32($sformatf("%s div_opa", tag), m.div_opa, a);
                    chk32($sformatf("%s div_opb", tag), m.div_opb, b);
                end
            end else begin
                chk1($sformatf("%s c%0d res_valid", tag, c), m.res_valid, 1'b1);
                chk1($sformatf("%s c%0d stall_req", tag, c), m.stall_req, 1'b0);
                chk1($sformatf("%s c%0d div_start", tag, c), m.div_start, 1'b0);
                chk32($sformatf("%s c%0d res_hi", tag, c), m.res_hi, exp_hi);
                chk32($sformatf("%s c%0d res_lo", tag, c), m.res_lo, exp_lo);
            end
        end
        next_cycle();
        idle_inputs();
        settle();
        chk1($sformatf("%s after res_valid", tag), m.res_valid, 1'b0);
        chk1($sformatf("%s after busy", tag), m.busy, 1'b0);
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    initial begin
        vec_t        tbl [9];
        int          a0;
        logic [3:0]  lines;
        logic [31:0] ra, rb;
        logic [63:0] r;

        tbl[0] = '{4'b1000, 32'd7,        32'hFFFF_FFFE, 33, 0, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[1] = '{4'b0100, 32'hFFFF_FFFF, 32'd16,       33, 0, 32'h0000_000F, 32'h0FFF_FFFF};
        tbl[2] = '{4'b0010, 32'hFFFF_FFFD, 32'd5,         0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[3] = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[4] = '{4'b0010, 32'h1234_5678, 32'h10,        0, 4, 32'h0000_0001, 32'h2345_6780};
        tbl[5] = '{4'b1011, 32'hFFFF_FFF9, 32'd2,         1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[6] = '{4'b0011, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 32'h0000_0000};
        tbl[7] = '{4'b0001, 32'h8000_0000, 32'd2,         0, 0, 32'h0000_0001, 32'h0000_0000};
        tbl[8] = '{4'b0101, 32'd100,       32'd7,         5, 2, 32'h0000_0002, 32'h0000_000E};

        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        settle();
        chk_all_zero("reset");
        next_cycle();
        rst = 1'b0;
        settle();

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), tbl[i].lines, tbl[i].a, tbl[i].b,
                  tbl[i].dlat, tbl[i].pst, tbl[i].hi, tbl[i].lo);

        // Flush in cycle 10 of a divide, then a stray ready while idle.
        a0 = annul_cnt;
        div_lat = 33;
        next_cycle();
        m.divE = 1'b1; m.srcaE = 32'd100; m.srcbE = 32'd7;
        settle();
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            settle();
            chk1($sformatf("flush10 c%0d div_annul", c), m.div_annul, 1'b0);
            chk1($sformatf("flush10 c%0d stall_req", c), m.stall_req, 1'b1);
        end
        next_cycle();
        m.flushE = 1'b1;
        settle();
        chk1("flush10 c10 div_annul", m.div_annul, 1'b1);
        chk1("flush10 c10 stall_req", m.stall_req, 1'b0);
        next_cycle();
        idle_inputs();
        settle();
        chk1("flush10 c11 busy", m.busy, 1'b0);
        chk1("flush10 c11 div_annul", m.div_annul, 1'b0);
        chk1("flush10 c11 res_valid", m.res_valid, 1'b0);
        chk32("flush10 annul pulses", 32'(annul_cnt - a0), 32'd1);
        next_cycle();
        stray_ready = 1'b1;
        settle();
        next_cycle();
        stray_ready = 1'b0;
        settle();
        chk1("stray ready busy", m.busy, 1'b0);
        chk1("stray ready res_valid", m.res_valid, 1'b0);
        chk32("stray ready res_lo", m.res_lo, last_lo);

        // Flush arriving together with div_ready discards the result.
        a0 = annul_cnt;
        div_lat = 3;
        next_cycle();
        m.divuE = 1'b1; m.srcaE = 32'd50; m.srcbE = 32'd3;
        settle();
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            settle();
        end
        next_cycle();
        m.flushE = 1'b1;
        settle();
        chk1("flush+ready div_ready seen", m.div_ready, 1'b1);
        chk1("flush+ready stall_req", m.stall_req, 1'b0);
        next_cycle();
        idle_inputs();
        settle();
        chk1("flush+ready busy", m.busy, 1'b0);
        chk1("flush+ready res_valid", m.res_valid, 1'b0);
        chk32("flush+ready res_hi", m.res_hi, last_hi);
        chk32("flush+ready res_lo", m.res_lo, last_lo);
        chk32("flush+ready annul pulses", 32'(annul_cnt - a0), 32'd1);

        // Flush arriving together with the last multiply count.
        next_cycle();
        m.multE = 1'b1; m.srcaE = 32'd3; m.srcbE = 32'd3;
        settle();
        for (int c = 1; c < MUL_CYCLES; c++) begin
            next_cycle();
            settle();
        end
        next_cycle();
        m.flushE = 1'b1;
        settle();
        next_cycle();
        idle_inputs();
        settle();
        chk1("mulflush busy", m.busy, 1'b0);
        chk1("mulflush res_valid", m.res_valid, 1'b0);
        chk32("mulflush res_lo", m.res_lo, last_lo);

        // Flush while held in DONE leaves without an annul.
        a0 = annul_cnt;
        next_cycle();
        m.multuE = 1'b1; m.srcaE = 32'd6; m.srcbE = 32'd7;
        settle();
        for (int c = 1; c <= MUL_CYCLES; c++) begin
            next_cycle();
            settle();
        end
        next_cycle();
        m.flushE = 1'b1; m.pipe_stall = 1'b1;
        settle();
        chk1("doneflush res_valid", m.res_valid, 1'b1);
        chk1("doneflush div_annul", m.div_annul, 1'b0);
        chk32("doneflush res_lo", m.res_lo, 32'd42);
        next_cycle();
        idle_inputs();
        settle();
        chk1("doneflush busy", m.busy, 1'b0);
        chk32("doneflush annul pulses", 32'(annul_cnt - a0), 32'd0);
        last_hi = 32'd0;
        last_lo = 32'd42;

        // A request in the same cycle as a flush is dropped.
        next_cycle();
        m.divE = 1'b1; m.flushE = 1'b1; m.srcaE = 32'd9; m.srcbE = 32'd9;
        settle();
        chk1("idleflush stall_req", m.stall_req, 1'b0);
        next_cycle();
        idle_inputs();
        settle();
        chk1("idleflush busy", m.busy, 1'b0);
        chk1("idleflush div_start", m.div_start, 1'b0);

        // Reset in the middle of a divide.
        div_lat = 33;
        next_cycle();
        m.divuE = 1'b1; m.srcaE = 32'd5; m.srcbE = 32'd3;
        settle();
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            settle();
        end
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        settle();
        chk1("midreset pre div_start", m.div_start, 1'b1);
        next_cycle();
        rst = 1'b0;
        settle();
        chk_all_zero("midreset");
        last_hi = 32'd0;
        last_lo = 32'd0;

        for (int i = 0; i < 40; i++) begin
            lines = 4'($urandom_range(1, 15));
            ra = $urandom;
            rb = $urandom;
            if ((prio(lines) == OP_DIV || prio(lines) == OP_DIVU) && rb == 32'd0)
                rb = 32'd1;
            r = ref_model(prio(lines), ra, rb);
            do_op($sformatf("rnd%0d", i), lines, ra, rb, $urandom_range(1, 40),
                  $urandom_range(0, 2), r[63:32], r[31:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
